// File: rtl/fu_arbiter_if.sv
// Handshake bundle between the two datapath clients, the result consumer and fu_arbiter.
// master = client/consumer side, slave = arbiter side.
interface fu_arbiter_if;
  logic       req0_valid, req0_ready;
  logic [2:0] req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [2:0] req1_op;
  logic [7:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, input req0_ready,
    output req1_valid, req1_op, req1_a, req1_b, input req1_ready,
    input  rsp_valid, rsp_data, rsp_id, output rsp_ready
  );
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, output req1_ready,
    output rsp_valid, rsp_data, rsp_id, input rsp_ready
  );
endinterface

// File: rtl/fu_arbiter.sv
// fu_arbiter: two requesters share one 8-bit Functional_Unit via an IDLE/EXEC/RESP FSM.
// Define FU_PERF_CNT_EN to add saturating per-requester accept counters cnt0/cnt1.
module Functional_Unit (
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] f
);
  always_comb begin
    f = 8'h00;
    case (op)
      3'b000: f = a + b;
      3'b001: f = a + ~b;
      3'b010: f = a & b;
      3'b011: f = a | b;
      3'b100: f = a ^ b;
      3'b101: f = {1'b0, a[7:1]} + b;
      3'b110: f = {a[0], a[7:1]} + b;
      3'b111: f = {a[6:0], a[7]} + b;
      default: f = 8'h00;
    endcase
  end
endmodule

module fu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  fu_arbiter_if.slave  bus,
  output logic         busy
`ifdef FU_PERF_CNT_EN
  ,
  output logic [15:0]  cnt0,
  output logic [15:0]  cnt1
`endif
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       id;
  } fu_req_t;

  state_t     state_q, state_d;
  fu_req_t    req_q, req_d;
  logic       last_id_q, last_id_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_id_q, rsp_id_d;
  logic       gnt0, gnt1, acc0, acc1;
  logic [7:0] fu_f;

  Functional_Unit u_fu (.op(req_q.op), .a(req_q.a), .b(req_q.b), .f(fu_f));

  // Tie goes to req0 in fixed mode, otherwise to whoever was not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      if (FIXED_PRIO || last_id_q) gnt0 = 1'b1;
      else                         gnt1 = 1'b1;
    end else begin
      gnt0 = bus.req0_valid;
      gnt1 = bus.req1_valid;
    end
  end

  assign bus.req0_ready = (state_q == IDLE) & gnt0 & ~rst;
  assign bus.req1_ready = (state_q == IDLE) & gnt1 & ~rst;
  assign acc0           = bus.req0_valid & bus.req0_ready;
  assign acc1           = bus.req1_valid & bus.req1_ready;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    last_id_d   = last_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: if (acc0 || acc1) begin
        req_d     = acc0 ? fu_req_t'{bus.req0_op, bus.req0_a, bus.req0_b, 1'b0}
                         : fu_req_t'{bus.req1_op, bus.req1_a, bus.req1_b, 1'b1};
        last_id_d = acc1;
        state_d   = EXEC;
      end
      EXEC: begin
        rsp_data_d  = fu_f;
        rsp_id_d    = req_q.id;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: if (rsp_valid_q && bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      last_id_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      last_id_q   <= last_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state_q != IDLE);

`ifdef FU_PERF_CNT_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (acc0 && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
    if (acc1 && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= 16'h0000;
      cnt1_q <= 16'h0000;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_fu_arbiter.sv
// Bench for fu_arbiter: round-robin (inst 0) and fixed-priority (inst 1) instances
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_fu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fu_arbiter_if ifa ();
  fu_arbiter_if ifb ();

  logic [1:0][1:0]      v;
  logic [1:0][1:0][2:0] op;
  logic [1:0][1:0][7:0] a, b;
  logic [1:0]           rr;
  logic [1:0][1:0]      rdy;
  logic [1:0]           rv, rid, busy_o;
  logic [1:0][7:0]      rd;
  logic [1:0][15:0]     cnt0_o, cnt1_o;

  assign ifa.req0_valid = v[0][0]; assign ifa.req0_op = op[0][0];
  assign ifa.req0_a = a[0][0];     assign ifa.req0_b = b[0][0];
  assign ifa.req1_valid = v[0][1]; assign ifa.req1_op = op[0][1];
  assign ifa.req1_a = a[0][1];     assign ifa.req1_b = b[0][1];
  assign ifa.rsp_ready = rr[0];
  assign ifb.req0_valid = v[1][0]; assign ifb.req0_op = op[1][0];
  assign ifb.req0_a = a[1][0];     assign ifb.req0_b = b[1][0];
  assign ifb.req1_valid = v[1][1]; assign ifb.req1_op = op[1][1];
  assign ifb.req1_a = a[1][1];     assign ifb.req1_b = b[1][1];
  assign ifb.rsp_ready = rr[1];
  assign rdy[0][0] = ifa.req0_ready; assign rdy[0][1] = ifa.req1_ready;
  assign rdy[1][0] = ifb.req0_ready; assign rdy[1][1] = ifb.req1_ready;
  assign rv[0] = ifa.rsp_valid; assign rd[0] = ifa.rsp_data; assign rid[0] = ifa.rsp_id;
  assign rv[1] = ifb.rsp_valid; assign rd[1] = ifb.rsp_data; assign rid[1] = ifb.rsp_id;

  fu_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst(rst), .bus(ifa.slave), .busy(busy_o[0])
`ifdef FU_PERF_CNT_EN
    , .cnt0(cnt0_o[0]), .cnt1(cnt1_o[0])
`endif
  );
  fu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .bus(ifb.slave), .busy(busy_o[1])
`ifdef FU_PERF_CNT_EN
    , .cnt0(cnt0_o[1]), .cnt1(cnt1_o[1])
`endif
  );
`ifndef FU_PERF_CNT_EN
  assign cnt0_o = '0;
  assign cnt1_o = '0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model: one op in flight, age = rising edges since accept.
  bit         m_inf [2];
  int         m_age [2];
  logic [7:0] m_res [2], m_data [2];
  logic       m_pid [2], m_id [2], m_last [2];
  int         m_cnt [2][2];

  function automatic logic [7:0] fu_ref(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int xi, yi, r;
    xi = x; yi = y; r = 0;
    case (o)
      3'd0: r = xi + yi;
      3'd1: r = xi + (255 - yi);
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = xi / 2 + yi;
      3'd6: r = xi / 2 + (xi % 2) * 128 + yi;
      default: r = (xi * 2) % 256 + xi / 128 + yi;
    endcase
    return 8'(r % 256);
  endfunction

  // Instance 1 is the fixed-priority one.
  function automatic int pick(input int k, input logic va, input logic vb);
    if (va && vb) return (k == 1) ? 0 : (m_last[k] ? 0 : 1);
    if (va) return 0;
    if (vb) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_inf[k] = 0; m_age[k] = 0; m_res[k] = 8'h00; m_data[k] = 8'h00;
      m_pid[k] = 1'b0; m_id[k] = 1'b0; m_last[k] = 1'b1;
      m_cnt[k][0] = 0; m_cnt[k][1] = 0;
    end
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic issue(input int j, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       output int waits);
    v[0][j] = 1'b1; op[0][j] = o; a[0][j] = x; b[0][j] = y;
    waits = 0;
    while (1) begin
      @(negedge clk);
      waits++;
      if (rdy[0][j]) break;
      if (waits >= 20) begin
        chk("accept_timeout", 0, 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    v[0][j] = 1'b0;
  endtask

  task automatic get_rsp(output logic [7:0] d, output logic id, output int lat);
    lat = 0;
    d = 8'h00; id = 1'b0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (rv[0]) begin
        d = rd[0]; id = rid[0];
        return;
      end
    end
    chk("rsp_timeout", 0, 0, 1);
  endtask

  task automatic run_op(input int j, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] expd, input string nm);
    int w, lat;
    logic [7:0] d;
    logic id;
    issue(j, o, x, y, w);
    get_rsp(d, id, lat);
    chk({nm, "_data"}, 0, d, expd);
    chk({nm, "_id"}, 0, id, j);
    chk({nm, "_lat"}, 0, lat, 2);
    @(posedge clk); #1;
  endtask

  initial begin
    int w, lat;
    logic [7:0] d;
    logic id;
    logic hs [2][2];
    int seq [2][$];
    int ex_rr [4];
    v = '0; op = '0; a = '0; b = '0; rr = 2'b11;
    model_reset();

    fork
      forever begin
        @(posedge clk or posedge rst);
        for (int k = 0; k < 2; k++) begin
          if (rst) begin
            m_inf[k] = 0; m_age[k] = 0; m_res[k] = 8'h00; m_data[k] = 8'h00;
            m_pid[k] = 1'b0; m_id[k] = 1'b0; m_last[k] = 1'b1;
            m_cnt[k][0] = 0; m_cnt[k][1] = 0;
          end else if (!m_inf[k]) begin
            int g;
            g = pick(k, v[k][0], v[k][1]);
            if (g >= 0) begin
              m_inf[k] = 1; m_age[k] = 0;
              m_res[k] = fu_ref(op[k][g], a[k][g], b[k][g]);
              m_pid[k] = g[0]; m_last[k] = g[0];
              if (m_cnt[k][g] < 65535) m_cnt[k][g]++;
            end
          end else if (m_age[k] >= 1) begin
            if (rr[k]) m_inf[k] = 0;
          end else begin
            m_age[k] = 1; m_data[k] = m_res[k]; m_id[k] = m_pid[k];
          end
        end
      end
      forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          int g;
          g = m_inf[k] ? -1 : pick(k, v[k][0], v[k][1]);
          chk("m_req0_ready", k, rdy[k][0], (!rst && g == 0));
          chk("m_req1_ready", k, rdy[k][1], (!rst && g == 1));
          chk("m_busy", k, busy_o[k], m_inf[k]);
          chk("m_rsp_valid", k, rv[k], (m_inf[k] && m_age[k] >= 1));
          chk("m_rsp_data", k, rd[k], m_data[k]);
          chk("m_rsp_id", k, rid[k], m_id[k]);
`ifdef FU_PERF_CNT_EN
          chk("m_cnt0", k, cnt0_o[k], m_cnt[k][0]);
          chk("m_cnt1", k, cnt1_o[k], m_cnt[k][1]);
`endif
        end
      end
    join_none

    // Reset held with req0 already valid.
    v[0][0] = 1'b1; op[0][0] = 3'b000; a[0][0] = 8'hF0; b[0][0] = 8'h20;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req0_ready", 0, rdy[0][0], 0);
      chk("rst_rsp_valid", 0, rv[0], 0);
      chk("rst_rsp_data", 0, rd[0], 8'h00);
      chk("rst_busy", 0, busy_o[0], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    issue(0, 3'b000, 8'hF0, 8'h20, w);
    chk("first_accept_wait", 0, w, 1);
    get_rsp(d, id, lat);
    chk("op000_data", 0, d, 8'h10);
    chk("op000_id", 0, id, 0);
    chk("op000_lat", 0, lat, 2);
    @(posedge clk); #1;

    run_op(1, 3'b001, 8'h05, 8'h03, 8'h01, "op001");
    run_op(0, 3'b101, 8'h81, 8'h01, 8'h41, "op101");
    run_op(0, 3'b110, 8'h01, 8'h00, 8'h80, "op110");
    run_op(0, 3'b111, 8'h80, 8'h01, 8'h02, "op111");
    run_op(1, 3'b010, 8'hCC, 8'hAA, 8'h88, "op010");
    run_op(0, 3'b011, 8'h0C, 8'hA0, 8'hAC, "op011");

    // Backpressure: response held 5 cycles while req1 waits.
    rr[0] = 1'b0;
    issue(0, 3'b100, 8'h3C, 8'h0F, w);
    get_rsp(d, id, lat);
    chk("bp_data", 0, d, 8'h33);
    repeat (5) begin
      @(posedge clk); #1;
      v[0][1] = 1'b1; op[0][1] = 3'b000; a[0][1] = 8'h01; b[0][1] = 8'h01;
      @(negedge clk);
      chk("bp_hold_valid", 0, rv[0], 1);
      chk("bp_hold_data", 0, rd[0], 8'h33);
      chk("bp_hold_id", 0, rid[0], 0);
      chk("bp_hold_rdy", 0, {rdy[0][1], rdy[0][0]}, 0);
    end
    @(posedge clk); #1;
    rr[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_accept", 0, rdy[0][1], 1);
    @(posedge clk); #1;
    v[0][1] = 1'b0;
    get_rsp(d, id, lat);
    chk("bp_next_data", 0, d, 8'h02);
    chk("bp_next_id", 0, id, 1);
    @(posedge clk); #1;

    // Counters, then reset while an op sits in EXEC.
    @(posedge clk); #2 rst = 1'b1; #3 rst = 1'b0;
    @(posedge clk); #1;
    repeat (3) run_op(0, 3'b000, 8'h11, 8'h22, 8'h33, "cnt_op");
`ifdef FU_PERF_CNT_EN
    @(negedge clk);
    chk("cnt0_after3", 0, cnt0_o[0], 3);
    chk("cnt1_after3", 0, cnt1_o[0], 0);
    @(posedge clk); #1;
`endif
    issue(0, 3'b000, 8'h01, 8'h02, w);
    #1 rst = 1'b1; #2 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_rsp", 0, rv[0], 0);
      chk("midrst_busy", 0, busy_o[0], 0);
`ifdef FU_PERF_CNT_EN
      chk("midrst_cnt0", 0, cnt0_o[0], 0);
      chk("midrst_cnt1", 0, cnt1_o[0], 0);
`endif
    end

    // Arbitration with both requesters continuously valid.
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 2; j++) begin
        v[k][j] = 1'b1; op[k][j] = 3'b000; a[k][j] = 8'(j); b[k][j] = 8'h00;
      end
    rr = 2'b11;
    repeat (16) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (rv[k]) seq[k].push_back(int'(rid[k]));
      chk("fp_req1_never_ready", 1, rdy[1][1], 0);
    end
    ex_rr = '{0, 1, 0, 1};
    for (int k = 0; k < 2; k++) begin
      chk("arb_seq_len", k, (seq[k].size() >= 4), 1);
      if (seq[k].size() >= 4)
        for (int i = 0; i < 4; i++)
          chk("arb_seq", k, seq[k][i], (k == 0) ? ex_rr[i] : 0);
    end
    @(posedge clk); #1;
    v = '0;

    // Randomized traffic on both instances.
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 2; j++) hs[k][j] = 1'b0;
    repeat (2000) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        for (int j = 0; j < 2; j++) hs[k][j] = v[k][j] & rdy[k][j];
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        rr[k] = ($urandom_range(0, 2) != 0);
        for (int j = 0; j < 2; j++)
          if (hs[k][j] || !v[k][j]) begin
            v[k][j]  = ($urandom_range(0, 3) != 0);
            op[k][j] = 3'($urandom_range(0, 7));
            a[k][j]  = 8'($urandom_range(0, 255));
            b[k][j]  = 8'($urandom_range(0, 255));
          end
      end
    end
    v = '0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
